mcu_core_param: RTL

Parametrised successor of the 8-bit accumulator MCU. It has configurable data, PC and operand widths, and a multi-cycle FETCH/EXECUTE/HALT controller. Instruction memory is external, reached through a req/ack handshake, so wait-state memories are supported. It sits at the top of the MCU hierarchy and replaces the fixed-width core.

---
 rtl/mcu_pkg.sv | 30 +++
 rtl/mcu_regfile.sv | 34 +++
 rtl/mcu_core_param.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared constants for the parametrised accumulator MCU: opcode values,
// controller state encoding and the fixed opcode field width.
package mcu_pkg;

    localparam int OPC_WIDTH = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JMPR = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/mcu_regfile.sv
// General-purpose register file: 2**OPND_WIDTH entries, one shared address
// for the combinational read and the synchronous write.
module mcu_regfile
    import mcu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OPND_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [OPND_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int REG_COUNT = 2 ** OPND_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];

    // Clear every entry on reset, otherwise write the addressed entry on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= '0;
            end
        end else if (load) begin
            regs_r[addr] <= wdata;
        end
    end

    assign rdata = regs_r[addr];

endmodule

// File: rtl/mcu_core_param.sv
// Parametrised accumulator MCU core with a FETCH/EXECUTE/HALT controller and
// a req/ack instruction port that tolerates wait-state memories.
module mcu_core_param
    import mcu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 8,
    parameter int OPND_WIDTH = 4
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [PC_WIDTH-1:0]             resetPC,
    output logic                            imem_req,
    output logic [PC_WIDTH-1:0]             imem_addr,
    input  logic                            imem_ack,
    input  logic [OPC_WIDTH+OPND_WIDTH-1:0] imem_data,
    output logic [PC_WIDTH-1:0]             currentPC,
    output logic [DATA_WIDTH-1:0]           acc_out,
    output logic                            flag_z,
    output logic                            flag_c,
    output logic                            halted
);

    localparam int IR_WIDTH = OPC_WIDTH + OPND_WIDTH;
    localparam logic [PC_WIDTH-1:0]   PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH:0]   SUM_ONE = {{DATA_WIDTH{1'b0}}, 1'b1};

    state_t                  state_r;
    logic [PC_WIDTH-1:0]     pc_r;
    logic [IR_WIDTH-1:0]     ir_r;
    logic [DATA_WIDTH-1:0]   acc_r;
    logic                    z_r;
    logic                    c_r;

    logic [OPC_WIDTH-1:0]    opcode_s;
    logic [OPND_WIDTH-1:0]   opnd_s;
    logic [DATA_WIDTH-1:0]   imm_s;
    logic [DATA_WIDTH-1:0]   reg_rd_s;
    logic                    reg_load_s;
    logic [DATA_WIDTH-1:0]   add_b_s;
    logic [DATA_WIDTH:0]     add_s;
    logic [DATA_WIDTH:0]     sub_s;
    logic [DATA_WIDTH-1:0]   alu_res_s;
    logic                    alu_c_s;
    logic                    acc_we_s;
    logic                    flag_upd_s;
    logic                    jump_s;
    logic [PC_WIDTH-1:0]     target_s;

    assign opcode_s   = ir_r[IR_WIDTH-1 -: OPC_WIDTH];
    assign opnd_s     = ir_r[OPND_WIDTH-1:0];
    assign imm_s      = DATA_WIDTH'(opnd_s);
    assign reg_load_s = (state_r == ST_EXEC) && (opcode_s == OP_STR);

    mcu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .OPND_WIDTH (OPND_WIDTH)
    ) u_regfile (
        .clk   (Clk),
        .reset (Reset),
        .load  (reg_load_s),
        .addr  (opnd_s),
        .wdata (acc_r),
        .rdata (reg_rd_s)
    );

    // Adder and subtractor carry one extra bit so the carry-out lands in the MSB.
    assign add_b_s = (opcode_s == OP_ADDI) ? imm_s : reg_rd_s;
    assign add_s   = {1'b0, acc_r} + {1'b0, add_b_s};
    assign sub_s   = {1'b0, acc_r} + {1'b0, ~reg_rd_s} + SUM_ONE;

    // Decode the IR into accumulator result, carry, flag update and branch target.
    always_comb begin
        alu_res_s  = acc_r;
        alu_c_s    = c_r;
        acc_we_s   = 1'b0;
        flag_upd_s = 1'b0;
        jump_s     = 1'b0;
        target_s   = PC_WIDTH'(opnd_s);
        case (opcode_s)
            OP_LDI: begin
                acc_we_s  = 1'b1;
                alu_res_s = imm_s;
            end
            OP_LDR: begin
                acc_we_s  = 1'b1;
                alu_res_s = reg_rd_s;
            end
            OP_ADD, OP_ADDI: begin
                acc_we_s   = 1'b1;
                flag_upd_s = 1'b1;
                alu_res_s  = add_s[DATA_WIDTH-1:0];
                alu_c_s    = add_s[DATA_WIDTH];
            end
            OP_SUB: begin
                acc_we_s   = 1'b1;
                flag_upd_s = 1'b1;
                alu_res_s  = sub_s[DATA_WIDTH-1:0];
                alu_c_s    = sub_s[DATA_WIDTH];
            end
            OP_AND: begin
                acc_we_s   = 1'b1;
                flag_upd_s = 1'b1;
                alu_res_s  = acc_r & reg_rd_s;
                alu_c_s    = 1'b0;
            end
            OP_OR: begin
                acc_we_s   = 1'b1;
                flag_upd_s = 1'b1;
                alu_res_s  = acc_r | reg_rd_s;
                alu_c_s    = 1'b0;
            end
            OP_XOR: begin
                acc_we_s   = 1'b1;
                flag_upd_s = 1'b1;
                alu_res_s  = acc_r ^ reg_rd_s;
                alu_c_s    = 1'b0;
            end
            OP_NOT: begin
                acc_we_s   = 1'b1;
                flag_upd_s = 1'b1;
                alu_res_s  = ~acc_r;
                alu_c_s    = 1'b0;
            end
            OP_JMP:  jump_s = 1'b1;
            OP_JMPR: begin
                jump_s   = 1'b1;
                target_s = PC_WIDTH'(reg_rd_s);
            end
            OP_JZ:   jump_s = z_r;
            OP_JC:   jump_s = c_r;
            default: begin
                alu_res_s = acc_r;
            end
        endcase
    end

    // Controller: fetch handshake, single-cycle execute, sticky halt.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_FETCH;
            pc_r    <= resetPC;
            ir_r    <= '0;
            acc_r   <= '0;
            z_r     <= 1'b0;
            c_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_r    <= imem_data;
                        pc_r    <= pc_r + PC_ONE;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (acc_we_s) begin
                        acc_r <= alu_res_s;
                    end
                    if (flag_upd_s) begin
                        z_r <= (alu_res_s == '0);
                        c_r <= alu_c_s;
                    end
                    if (jump_s) begin
                        pc_r <= target_s;
                    end
                    state_r <= (opcode_s == OP_HLT) ? ST_HALT : ST_FETCH;
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_FETCH;
            endcase
        end
    end

    // Request and halt indication are forced low while Reset is held.
    assign imem_req  = (state_r == ST_FETCH) && !Reset;
    assign halted    = (state_r == ST_HALT) && !Reset;
    assign imem_addr = pc_r;
    assign currentPC = pc_r;
    assign acc_out   = acc_r;
    assign flag_z    = z_r;
    assign flag_c    = c_r;

endmodule
